// File: rtl/fetch_control.sv
// Instruction fetch sequencer: walks IDLE -> T0 -> T1 -> T2 -> DEC -> EXEC,
// loading AR from PC, reading one word into IR, and then handing control to
// the execute stage until it reports completion.
module fetch_control #(
  parameter int n = 16,  // data word / IR width (at least 16)
  parameter int a = 12   // PC / AR width
) (
  input  logic         clk,
  input  logic         clear,
  input  logic         start,
  input  logic         halt,
  input  logic         mem_ready,
  input  logic [n-1:0] mem_data,
  input  logic         exec_done,
  input  logic         jump,
  input  logic [a-1:0] jump_addr,
  output logic         mem_rd,
  output logic [a-1:0] mem_addr,
  output logic [a-1:0] pc,
  output logic [n-1:0] ir,
  output logic [2:0]   opcode,
  output logic         ind,
  output logic [2:0]   sc,
  output logic         fetch_done
);

  // The state encoding doubles as the externally visible timing count.
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    T0   = 3'd1,
    T1   = 3'd2,
    T2   = 3'd3,
    DEC  = 3'd4,
    EXEC = 3'd5
  } state_t;

  state_t         state_q, state_d;
  logic [a-1:0]   pc_q, pc_d;
  logic [a-1:0]   ar_q, ar_d;
  logic [n-1:0]   ir_q, ir_d;
  logic           halt_q, halt_d;  // halt seen during a fetch, acted on at DEC

  // State and datapath registers; clear overrides every other input.
  always_ff @(posedge clk) begin
    if (clear) begin
      state_q <= IDLE;
      pc_q    <= '0;
      ar_q    <= '0;
      ir_q    <= '0;
      halt_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ar_q    <= ar_d;
      ir_q    <= ir_d;
      halt_q  <= halt_d;
    end
  end

  // Next-state, datapath updates and the two strobes.
  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    ar_d       = ar_q;
    ir_d       = ir_q;
    halt_d     = halt_q;
    mem_rd     = 1'b0;
    fetch_done = 1'b0;
    case (state_q)
      IDLE: begin
        halt_d = 1'b0;
        if (jump) pc_d = jump_addr;
        if (start && !halt) state_d = T0;
      end
      T0: begin
        ar_d = pc_q;
        if (halt) halt_d = 1'b1;
        state_d = T1;
      end
      T1: begin
        // Read stays requested for as long as memory keeps us waiting.
        mem_rd = 1'b1;
        if (halt) halt_d = 1'b1;
        if (mem_ready) begin
          ir_d    = mem_data;
          pc_d    = pc_q + a'(1);  // wraps naturally at 2^a
          state_d = T2;
        end
      end
      T2: begin
        if (halt) halt_d = 1'b1;
        state_d = DEC;
      end
      DEC: begin
        fetch_done = 1'b1;
        // A halt requested anywhere in the fetch lets it finish, then parks.
        if (halt || halt_q) begin
          halt_d  = 1'b0;
          state_d = IDLE;
        end else begin
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (jump) pc_d = jump_addr;
        if (exec_done) state_d = halt ? IDLE : T0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign mem_addr = ar_q;
  assign pc       = pc_q;
  assign ir       = ir_q;
  assign opcode   = ir_q[14:12];
  assign ind      = ir_q[15];
  assign sc       = state_q;

endmodule

// File: tb/tb_fetch_control.sv
// Directed bench for fetch_control. Each expected fetch result is queued by
// the stimulus process; a monitor pops and checks it whenever fetch_done is
// seen. Inputs change and outputs are sampled on the falling clock edge.
module tb_fetch_control;

  logic        clk;
  logic        clear, start, halt, mem_ready, exec_done, jump;
  logic [15:0] mem_data;
  logic [11:0] jump_addr;
  logic        mem_rd, ind, fetch_done;
  logic [11:0] mem_addr, pc;
  logic [15:0] ir;
  logic [2:0]  opcode, sc;

  typedef struct {
    logic [15:0] ir;
    logic [11:0] pc;
    logic [11:0] addr;
  } exp_t;

  exp_t exp_q[$];
  int   n_pass  = 0;
  int   n_total = 0;

  fetch_control #(.n(16), .a(12)) dut (
    .clk(clk), .clear(clear), .start(start), .halt(halt),
    .mem_ready(mem_ready), .mem_data(mem_data), .exec_done(exec_done),
    .jump(jump), .jump_addr(jump_addr), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .pc(pc), .ir(ir), .opcode(opcode), .ind(ind),
    .sc(sc), .fetch_done(fetch_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic push(input logic [15:0] i, input logic [11:0] p,
                      input logic [11:0] ad);
    exp_t e;
    e.ir = i; e.pc = p; e.addr = ad;
    exp_q.push_back(e);
  endtask

  // Monitor: every fetch_done must match the oldest queued expectation.
  always @(negedge clk) begin
    if (fetch_done === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_fetch_done: got pulse, expected none (ir=0x%0h)", ir);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("fetch_ir", 32'(ir), 32'(e.ir));
        chk("fetch_opcode", 32'(opcode), 32'(e.ir[14:12]));
        chk("fetch_ind", 32'(ind), 32'(e.ir[15]));
        chk("fetch_pc", 32'(pc), 32'(e.pc));
        chk("fetch_addr", 32'(mem_addr), 32'(e.addr));
        $display("fetch: ir=0x%04h pc=0x%03h addr=0x%03h", ir, pc, mem_addr);
      end
    end
  end

  initial begin
    clear = 1'b1; start = 1'b0; halt = 1'b0; mem_ready = 1'b0;
    exec_done = 1'b0; jump = 1'b0; mem_data = '0; jump_addr = '0;
    step(); step();
    clear = 1'b0;
    chk("reset_sc", 32'(sc), 0);
    chk("reset_pc", 32'(pc), 0);
    chk("reset_ir", 32'(ir), 0);
    chk("reset_mem_rd", 32'(mem_rd), 0);
    chk("reset_fetch_done", 32'(fetch_done), 0);

    // Basic fetch with memory always ready.
    mem_ready = 1'b1; mem_data = 16'h7123;
    push(16'h7123, 12'h001, 12'h000);
    start = 1'b1; step(); start = 1'b0;
    chk("t0_sc", 32'(sc), 1);
    chk("t0_mem_rd", 32'(mem_rd), 0);
    step();
    chk("t1_sc", 32'(sc), 2);
    chk("t1_mem_rd", 32'(mem_rd), 1);
    chk("t1_addr", 32'(mem_addr), 0);
    step();
    chk("t2_sc", 32'(sc), 3);
    chk("t2_ir", 32'(ir), 32'h7123);
    chk("t2_pc", 32'(pc), 1);
    step();
    chk("dec_sc", 32'(sc), 4);
    step();
    chk("exec_sc", 32'(sc), 5);
    chk("exec_no_fd", 32'(fetch_done), 0);

    // Jump together with exec_done: next fetch uses the target.
    jump = 1'b1; jump_addr = 12'h0A0; exec_done = 1'b1; mem_data = 16'h8A5C;
    step();
    jump = 1'b0; exec_done = 1'b0;
    chk("jmp_sc", 32'(sc), 1);
    chk("jmp_pc", 32'(pc), 32'h0A0);
    push(16'h8A5C, 12'h0A1, 12'h0A0);
    step();
    chk("jmp_addr", 32'(mem_addr), 32'h0A0);
    step(); step(); step();
    chk("jmp_exec_sc", 32'(sc), 5);

    // exec_done with halt returns to IDLE.
    exec_done = 1'b1; halt = 1'b1; step();
    exec_done = 1'b0; halt = 1'b0;
    chk("halt_exec_sc", 32'(sc), 0);
    chk("halt_exec_pc", 32'(pc), 32'h0A1);

    // PC wrap: preset 0xFFF in IDLE.
    jump = 1'b1; jump_addr = 12'hFFF; step(); jump = 1'b0;
    chk("idle_jump_pc", 32'(pc), 32'hFFF);
    mem_data = 16'h1234;
    push(16'h1234, 12'h000, 12'hFFF);
    start = 1'b1; step(); start = 1'b0;
    step();
    chk("wrap_addr", 32'(mem_addr), 32'hFFF);
    step();
    chk("wrap_pc", 32'(pc), 0);
    step(); step();

    // Delayed mem_ready: T1 holds with mem_rd high and IR unchanged.
    exec_done = 1'b1; mem_ready = 1'b0; mem_data = 16'h5555;
    step(); exec_done = 1'b0;
    step();
    for (int i = 0; i < 5; i++) begin
      chk("wait_mem_rd", 32'(mem_rd), 1);
      chk("wait_sc", 32'(sc), 2);
      chk("wait_ir", 32'(ir), 32'h1234);
      step();
    end
    mem_ready = 1'b1; mem_data = 16'hF00D;
    push(16'hF00D, 12'h001, 12'h000);
    step(); step(); step();
    chk("after_wait_sc", 32'(sc), 5);

    // Halt pulse in T1: fetch completes once, then IDLE.
    exec_done = 1'b1; mem_ready = 1'b0; mem_data = 16'h2A01;
    step(); exec_done = 1'b0;
    step();
    halt = 1'b1; step(); halt = 1'b0;
    push(16'h2A01, 12'h002, 12'h001);
    mem_ready = 1'b1;
    step(); step(); step();
    chk("halt_t1_sc", 32'(sc), 0);
    chk("halt_t1_fd", 32'(fetch_done), 0);
    exec_done = 1'b1; step(); exec_done = 1'b0;
    chk("halt_t1_exec_ignored", 32'(sc), 0);

    // start together with halt in IDLE is refused.
    start = 1'b1; halt = 1'b1; step(); start = 1'b0; halt = 1'b0;
    chk("start_halt_idle", 32'(sc), 0);

    // Clear during a T1 wait, with a halt already latched.
    mem_ready = 1'b0;
    start = 1'b1; step(); start = 1'b0;
    step();
    halt = 1'b1; step(); halt = 1'b0;
    step();
    clear = 1'b1; step(); clear = 1'b0;
    chk("clr_sc", 32'(sc), 0);
    chk("clr_mem_rd", 32'(mem_rd), 0);
    chk("clr_pc", 32'(pc), 0);
    chk("clr_ir", 32'(ir), 0);
    chk("clr_addr", 32'(mem_addr), 0);

    // After clear the latched halt is gone: the next fetch reaches EXEC.
    mem_ready = 1'b1; mem_data = 16'h3456;
    push(16'h3456, 12'h001, 12'h000);
    start = 1'b1; step(); start = 1'b0;
    step(); step(); step(); step();
    chk("post_clr_exec_sc", 32'(sc), 5);

    step(); step();
    n_total++;
    if (exp_q.size() == 0) n_pass++;
    else $display("FAIL missing_fetch_done: got %0d pending, expected 0", exp_q.size());

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/fetch_control.md
FETCH_CONTROL -- requirements
Module: fetch_control

Interface
REQ-001 Parameter n, default 16: memory data word and IR width; n SHALL be at least 16.
REQ-002 Parameter a, default 12: address width of PC and AR.
REQ-003 clk  input  1  single clock; all state SHALL change on posedge clk.
REQ-004 clear  input  1  reset; synchronous and active-high.
REQ-005 start  input  1  one-cycle request to begin fetching from the current PC.
REQ-006 halt  input  1  stop request; sampled in every state.
REQ-007 mem_ready  input  1  memory responder: mem_data valid this cycle.
REQ-008 mem_data  input  n  memory read data.
REQ-009 exec_done  input  1  execute stage finished the current instruction.
REQ-010 jump  input  1  load PC from jump_addr.
REQ-011 jump_addr  input  a  branch target.
REQ-012 mem_rd  output  1  read request to memory; address is mem_addr.
REQ-013 mem_addr  output  a  current AR value.
REQ-014 pc  output  a  program counter.
REQ-015 ir  output  n  instruction register.
REQ-016 opcode  output  3  ir[14:12].
REQ-017 ind  output  1  ir[15], the indirect bit.
REQ-018 sc  output  3  timing count; equals the state encoding in REQ-020.
REQ-019 fetch_done  output  1  one-cycle pulse when a new IR is valid.

Function
REQ-020 FSM states and sc encoding: IDLE=0, T0=1, T1=2, T2=3, DEC=4, EXEC=5.
REQ-021 IDLE: start=1 and halt=0 -> T0 next cycle; otherwise remain in IDLE.
REQ-022 T0: AR <= PC; -> T1.
REQ-023 T1: mem_rd=1 combinationally for every cycle in T1.
REQ-024 T1, mem_ready=1: IR <= mem_data; PC <= PC+1; -> T2.
REQ-025 T1, mem_ready=0: hold all state and stay in T1; there is no timeout.
REQ-026 mem_ready in any state other than T1 SHALL be ignored.
REQ-027 T2: -> DEC unconditionally.
REQ-028 DEC: fetch_done=1 for exactly this one cycle; -> EXEC.
REQ-029 EXEC: wait for exec_done.
REQ-030 exec_done=1 in EXEC: -> T0, or -> IDLE if halt=1 in the same cycle.
REQ-031 Load latency: start at cycle k -> mem_rd first high at k+2; mem_ready at cycle m -> fetch_done at m+2.
REQ-032 PC increment SHALL wrap modulo 2^a, so 0xFFF+1 = 0x000.
REQ-033 jump=1 in EXEC or IDLE: PC <= jump_addr; ignored in T0, T1, T2 and DEC.
REQ-034 jump and exec_done in the same EXEC cycle: PC <= jump_addr, and the next T0 uses the new PC.
REQ-035 halt in T0, T1, T2 or DEC SHALL be latched; the current fetch completes through DEC; the FSM then returns to IDLE instead of entering EXEC, and no further fetch_done occurs.
REQ-036 start outside IDLE SHALL be ignored; start and halt together in IDLE -> stay IDLE.
REQ-037 opcode and ind SHALL be pure decodes of ir.

Reset
REQ-038 clear=1 at posedge clk, in any state including mid-T1 wait: next state is IDLE; PC, AR and IR = 0; the latched halt is cleared; mem_rd=0; fetch_done=0; sc=0.
REQ-039 clear SHALL take priority over start, mem_ready, jump, exec_done and halt.

Verification
REQ-040 Clear, then start with mem_ready tied high and mem_data=0x7123 -> mem_rd at cycle 2, mem_addr=0, ir=0x7123, opcode=7, ind=0, pc=1, fetch_done at cycle 4.
REQ-041 PC preset to 0xFFF via jump in IDLE, then start -> mem_addr=0xFFF, pc=0x000 after T1.
REQ-042 mem_ready delayed 5 cycles in T1 -> mem_rd high all 5 cycles, sc=2 held, ir unchanged until ready.
REQ-043 In EXEC, assert jump (jump_addr=0x0A0) and exec_done together -> next mem_addr=0x0A0.
REQ-044 Halt pulse in T1 -> fetch completes, one fetch_done, then IDLE (sc=0); exec_done afterwards has no effect.
REQ-045 Clear asserted during a T1 wait -> next cycle sc=0, mem_rd=0, pc=0, ir=0.
